fraction_mac_relu: RTL and testbench

FRACTION_MAC_RELU -- requirements
Module: fraction_mac_relu

---
 rtl/fraction_mac_relu.sv | 120 ++++++++++++
 tb/tb_fraction_mac_relu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fraction_mac_relu.sv
// fraction_mac_relu
// Three-tap fixed-point multiply-accumulate with a bias term and a ReLU.
// Per-step saturating adds are followed by a registered ReLU output.
// After a reset the block takes one Q1.11 sample per cycle for three
// cycles. It then accumulates BIAS + sum(sample_k * Wk) in Q10.13 and
// presents ReLU(sum) with valid held high until the next reset. Each
// add saturates, so an intermediate overflow can never wrap the sign.
module fraction_mac_relu #(
    parameter logic signed [2:0]  W0   = 3'b001,
    parameter logic signed [2:0]  W1   = 3'b010,
    parameter logic signed [2:0]  W2   = 3'b011,
    parameter logic signed [22:0] BIAS = 23'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] in_data,
    output logic [22:0] out_data,
    output logic        valid
);

    // S0..S2 consume samples 0..2, S3 folds in the last product, and S4
    // is the terminal hold state.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } step_t;

    step_t step;

    logic [22:0] num1;
    logic [22:0] num2;
    logic [22:0] acc;

    logic signed [2:0]  weight;
    logic signed [14:0] product;
    logic [22:0]        product_ext;
    logic [23:0]        sum_wide;
    logic [22:0]        sum_sat;
    logic [22:0]        relu_out;

    // Pick the weight for the sample being consumed in this step.
    always_comb begin
        weight = 3'sd0;
        case (step)
            S0:      weight = W0;
            S1:      weight = W1;
            S2:      weight = W2;
            default: weight = 3'sd0;
        endcase
    end

    // Q1.11 x Q1.2 gives an exact Q2.13 value, so no rounding is needed.
    // The result is sign-extended into the Q10.13 accumulator format.
    assign product     = $signed(in_data) * weight;
    assign product_ext = {{8{product[14]}}, product};

    // Add one guard bit. The top two bits of the sum expose the overflow
    // direction: 01 means the sum passed positive full scale and 10 means
    // it passed negative full scale.
    assign sum_wide = {num1[22], num1} + {num2[22], num2};

    // Clamp the sum to the representable Q10.13 range.
    always_comb begin
        sum_sat = sum_wide[22:0];
        if (sum_wide[23:22] == 2'b01) begin
            sum_sat = 23'h3FFFFF;
        end else if (sum_wide[23:22] == 2'b10) begin
            sum_sat = 23'h400000;
        end
    end

    // Clamp a negative accumulated value to zero.
    assign relu_out = acc[22] ? 23'h000000 : acc;

    // Step sequencing, operand registers, and the registered result.
    // Reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            step     <= S0;
            num1     <= '0;
            num2     <= '0;
            acc      <= '0;
            out_data <= '0;
            valid    <= 1'b0;
        end else begin
            case (step)
                S0: begin
                    num1 <= BIAS;
                    num2 <= product_ext;
                    step <= S1;
                end
                S1: begin
                    num1 <= sum_sat;
                    num2 <= product_ext;
                    step <= S2;
                end
                S2: begin
                    num1 <= sum_sat;
                    num2 <= product_ext;
                    step <= S3;
                end
                S3: begin
                    acc  <= sum_sat;
                    step <= S4;
                end
                default: begin
                    // Capture the result once; later edges re-load the
                    // same value, so the output and valid stay put.
                    out_data <= relu_out;
                    valid    <= 1'b1;
                    step     <= S4;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fraction_mac_relu.sv
// Bench for fraction_mac_relu. Four instances with different weights and
// biases share one clock, reset and sample stream. Every output is
// compared against an integer-arithmetic reference model.
module tb_fraction_mac_relu;

    localparam int N = 4;

    // Per-instance configuration, mirrored into the model below.
    localparam logic [22:0] B0 = 23'h000000;
    localparam logic [22:0] B1 = 23'h7FF000;
    localparam logic [22:0] B2 = 23'h3FFFFF;
    localparam logic [22:0] B3 = 23'h400000;
    localparam logic [2:0]  D3_W0 = 3'b100;
    localparam logic [2:0]  D3_W1 = 3'b011;
    localparam logic [2:0]  D3_W2 = 3'b011;

    logic        clk;
    logic        rst;
    logic [11:0] in_data;
    logic [22:0] out_data [N];
    logic        valid    [N];

    logic [22:0] bias_v [N];
    logic [2:0]  wa_v   [N];
    logic [2:0]  wb_v   [N];
    logic [2:0]  wc_v   [N];

    logic [22:0] exp_q    [N][$];
    logic [22:0] exp_last [N];
    logic        valid_prev [N];

    int checks;
    int errors;

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    fraction_mac_relu dut0 (
        .clk(clk), .rst(rst), .in_data(in_data),
        .out_data(out_data[0]), .valid(valid[0])
    );

    fraction_mac_relu #(.BIAS(B1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data),
        .out_data(out_data[1]), .valid(valid[1])
    );

    fraction_mac_relu #(.BIAS(B2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data),
        .out_data(out_data[2]), .valid(valid[2])
    );

    fraction_mac_relu #(.W0(D3_W0), .W1(D3_W1), .W2(D3_W2), .BIAS(B3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data),
        .out_data(out_data[3]), .valid(valid[3])
    );

    // Reference model. The result is ReLU(sat(sat(sat(bias + p0) + p1) + p2)).
    // Q1.11 times Q1.2 is an integer product already scaled to 2^-13.
    function automatic logic [22:0] ref_mac(input logic [22:0] bias,
                                            input logic [2:0] w0, input logic [2:0] w1,
                                            input logic [2:0] w2, input logic [11:0] s0,
                                            input logic [11:0] s1, input logic [11:0] s2);
        int acc;
        int prods [3];
        logic [22:0] r;
        prods[0] = int'($signed(s0)) * int'($signed(w0));
        prods[1] = int'($signed(s1)) * int'($signed(w1));
        prods[2] = int'($signed(s2)) * int'($signed(w2));
        acc = int'($signed(bias));
        for (int i = 0; i < 3; i++) begin
            acc = acc + prods[i];
            if (acc > 4194303)  acc = 4194303;
            if (acc < -4194304) acc = -4194304;
        end
        if (acc < 0) acc = 0;
        r = acc[22:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor. On each rising valid, pop the next expected value and
    // compare it with the output.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (valid[k] === 1'b1 && valid_prev[k] !== 1'b1) begin
                checks++;
                if (exp_q[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid dut%0d: actual=%h required=none", k, out_data[k]);
                end else begin
                    logic [22:0] e;
                    e = exp_q[k].pop_front();
                    if (out_data[k] !== e) begin
                        errors++;
                        $display("FAIL result dut%0d: actual=%h required=%h", k, out_data[k], e);
                    end
                end
            end
            valid_prev[k] = valid[k];
        end
    end

    // Pulse reset for one edge and check that every instance is cleared.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_data = 12'($urandom);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("reset_out dut%0d", k), out_data[k], 23'h0);
            check($sformatf("reset_valid dut%0d", k), {22'h0, valid[k]}, 23'h0);
        end
    endtask

    // One full computation. The expected values are pushed when the
    // samples are issued. The monitor pops them when valid rises on the
    // 5th edge. The driver confirms valid is still low after the 4th edge
    // and that nothing is left unpopped one cycle after the 5th edge.
    task automatic run_seq(input logic [11:0] s0, input logic [11:0] s1, input logic [11:0] s2);
        do_reset();
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_last[k] = ref_mac(bias_v[k], wa_v[k], wb_v[k], wc_v[k], s0, s1, s2);
            exp_q[k].push_back(exp_last[k]);
        end
        in_data = s0;
        @(negedge clk);
        in_data = s1;
        @(negedge clk);
        in_data = s2;
        @(negedge clk);
        in_data = 12'($urandom);
        @(negedge clk);
        for (int k = 0; k < N; k++)
            check($sformatf("early_valid dut%0d", k), {22'h0, valid[k]}, 23'h0);
        in_data = 12'($urandom);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL missing_valid dut%0d: actual=valid_low required=valid_by_edge5", k);
                exp_q[k].delete();
            end
        end
    endtask

    // Drive random samples while the block holds its result, then confirm
    // that a single reset clears the output and valid.
    task automatic hold_check();
        for (int c = 0; c < 10; c++) begin
            in_data = 12'($urandom);
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                check($sformatf("hold_out dut%0d", k), out_data[k], exp_last[k]);
                check($sformatf("hold_valid dut%0d", k), {22'h0, valid[k]}, 23'h1);
            end
        end
        do_reset();
    endtask

    // Start a sequence, then reset while the block is in S2.
    task automatic abort_in_s2();
        do_reset();
        rst = 1'b0;
        in_data = 12'h7FF;
        @(negedge clk);
        in_data = 12'h7FF;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("midreset_out dut%0d", k), out_data[k], 23'h0);
            check($sformatf("midreset_valid dut%0d", k), {22'h0, valid[k]}, 23'h0);
        end
    endtask

    // Stimulus.
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_data = '0;
        bias_v = '{B0, B1, B2, B3};
        wa_v = '{3'b001, 3'b001, 3'b001, D3_W0};
        wb_v = '{3'b010, 3'b010, 3'b010, D3_W1};
        wc_v = '{3'b011, 3'b011, 3'b011, D3_W2};
        for (int k = 0; k < N; k++) valid_prev[k] = 1'b0;
        repeat (2) @(negedge clk);

        // Directed cases: a positive sum, a negative clamp, and the
        // saturation extremes.
        run_seq(12'h400, 12'h400, 12'h400);
        check("directed_pos dut0", out_data[0], 23'h001800);
        check("directed_bias dut1", out_data[1], 23'h000800);
        check("directed_sat dut2", out_data[2], 23'h3FFFFF);
        hold_check();
        run_seq(12'hC00, 12'hC00, 12'hC00);
        check("directed_neg dut0", out_data[0], 23'h000000);
        run_seq(12'h7FF, 12'h7FF, 12'h7FF);
        check("directed_max dut2", out_data[2], 23'h3FFFFF);

        // Reset in S2, then rerun the positive-sum case.
        abort_in_s2();
        run_seq(12'h400, 12'h400, 12'h400);
        check("rerun_pos dut0", out_data[0], 23'h001800);

        // Random samples, including the full-scale corners.
        for (int t = 0; t < 30; t++) begin
            logic [11:0] r [3];
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 5))
                    0:       r[i] = 12'h7FF;
                    1:       r[i] = 12'h800;
                    default: r[i] = 12'($urandom);
                endcase
            end
            run_seq(r[0], r[1], r[2]);
            if (t % 10 == 0) hold_check();
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
